// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell shared with the carry-select adder; purely combinational.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder, LSB-first, carry held in a flip-flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    FullAdder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // NOTE: datapath registers are reset too, so an aborted addition leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= c_in;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    s_sr    <= {fa_sum, s_sr[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt     <= cnt + 1'b1;
                    // Final bit: publish the completed word, not the stale s_sr.
                    if (cnt == LAST) begin
                        sum      <= {fa_sum, s_sr[WIDTH-1:1]};
                        c_out    <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        overflow <= carry_q ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
